serial_bit_tx: RTL and testbench
================================

SERIAL_BIT_TX -- requirements
Module: serial_bit_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 4, giving clock cycles per serial bit (legal range >= 1).
REQ-002 The block SHALL have parameter DATA_W, default 8, giving the payload width in bits (legal range >= 1).
REQ-003 The block SHALL have port clk, input, 1 bit: clock, all state updates on the rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 The block SHALL have port tx_data, input, DATA_W bits: word to transmit, sampled on acceptance only.
REQ-006 The block SHALL have port tx_valid, input, 1 bit: tx_data holds a word to send.
REQ-007 The block SHALL have port tx_ready, output, 1 bit: block can accept a word this cycle.
REQ-008 The block SHALL have port sout, output, 1 bit: serial line, idle high.
REQ-009 The block SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-010 The block SHALL have port done, output, 1 bit: one-cycle pulse marking frame completion.

Function
REQ-011 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-013 Acceptance SHALL occur on a rising edge where tx_valid=1 and tx_ready=1; tx_data SHALL be latched into a shift register at that edge.
REQ-014 On acceptance, IDLE->START at the same edge, so sout=0 in the first cycle after the acceptance edge.
REQ-015 Every bit (start, data, parity, stop) SHALL hold sout stable for exactly CLKS_PER_BIT cycles, timed by a cycle counter that resets at each bit boundary.
REQ-016 START SHALL drive sout=0, then go to DATA.
REQ-017 DATA SHALL send DATA_W bits LSB first, tracked by a bit counter of width clog2(DATA_W)+1, then go to PARITY after bit DATA_W-1.
REQ-018 PARITY SHALL drive even parity: XOR of all latched bits, so the total count of ones over data plus parity is even.
REQ-019 STOP SHALL drive sout=1, then go to IDLE.
REQ-020 Frame length SHALL be (DATA_W+3)*CLKS_PER_BIT cycles, measured from the acceptance edge to the IDLE-return edge.
REQ-021 At the IDLE-return edge, done SHALL be set to 1 for exactly one cycle, and tx_ready SHALL be set to 1 at the same edge.
REQ-022 tx_ready SHALL be 1 only in IDLE; busy SHALL equal NOT tx_ready.
REQ-023 tx_data and tx_valid changes while busy SHALL be ignored.
REQ-024 With tx_valid held high, back-to-back frames SHALL be separated by exactly one idle cycle with sout=1, the IDLE cycle in which acceptance occurs.
REQ-025 CLKS_PER_BIT=1 SHALL work, giving one cycle per bit.
REQ-026 Illegal state encodings SHALL recover to IDLE on the next edge, with sout=1.

Reset
REQ-027 While reset=1, outputs SHALL be asynchronously forced to sout=1, tx_ready=1, busy=0 and done=0, and state SHALL be forced to IDLE with all counters and the shift register cleared.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately with no done pulse; the first acceptance SHALL be possible on the first rising edge after reset deasserts.

Verification (CLKS_PER_BIT=4, DATA_W=8 unless stated)
REQ-029 Send 0xA5 -> sout per 4-cycle bit: 0 | 1,0,1,0,0,1,0,1 | parity 0 | 1; done pulses at acceptance+44 cycles; tx_ready=0 for those 44 cycles.
REQ-030 Send 0x07 -> data bits 1,1,1,0,0,0,0,0, parity 1, stop 1; busy=1 for exactly 44 cycles.
REQ-031 Hold tx_valid=1 with 0x3C then 0xFF -> two complete frames, exactly one sout=1 idle cycle between the first stop bit and the second start bit, and two done pulses.
REQ-032 Assert reset for 1 cycle during data bit 3 -> sout=1, tx_ready=1 and busy=0 before the next edge, no done pulse, and the next 0x5A frame is correct.
REQ-033 Change tx_data from 0x00 to 0xFF while a 0x00 frame is busy -> data bits all 0, parity 0.
REQ-034 With CLKS_PER_BIT=1, send 0x81 -> sout=0,1,0,0,0,0,0,0,1,0,1 over 11 cycles, and done at acceptance+11.

Source files
------------

// File: rtl/serial_bit_tx.sv
// ---------------------------------------------------------------------------
// serial_bit_tx
//
// Purpose:
//   Serialises one DATA_W-bit word per frame onto a single line that idles
//   high. Frame format: start bit (0), DATA_W data bits LSB first, one even
//   parity bit, stop bit (1). Every bit is held for CLKS_PER_BIT clocks.
//   All outputs come straight from flops; nothing combinational reaches a
//   port.
//
// Parameters:
//   CLKS_PER_BIT - clocks per serial bit (>= 1)
//   DATA_W       - payload width in bits (>= 1)
//
// Ports:
//   clk      in   clock, rising-edge
//   reset    in   asynchronous, active-high reset
//   tx_data  in   word to send, captured only on the accepting edge
//   tx_valid in   tx_data holds a word to send
//   tx_ready out  high only while idle; an edge with tx_valid & tx_ready
//                 accepts the word
//   sout     out  serial line, idle high
//   busy     out  frame in progress (always the inverse of tx_ready)
//   done     out  one-cycle pulse in the cycle after the frame's last edge
// ---------------------------------------------------------------------------
module serial_bit_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              sout,
    output logic              busy,
    output logic              done
);

    // A one-cycle bit needs no counting, but a zero-width vector is not
    // legal, so the cycle counter keeps at least one bit.
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(DATA_W) + 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t            state_q,    state_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q,  bit_cnt_d;
    logic [DATA_W-1:0] shift_q,    shift_d;
    logic              parity_q,   parity_d;
    logic              sout_q,     sout_d;
    logic              tx_ready_q, tx_ready_d;
    logic              busy_q,     busy_d;
    logic              done_q,     done_d;

    logic              bit_end;

    // Last clock of the bit currently on the line.
    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        sout_d     = sout_q;
        tx_ready_d = tx_ready_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                sout_d     = 1'b1;
                tx_ready_d = 1'b1;
                busy_d     = 1'b0;
                cnt_d      = '0;
                bit_cnt_d  = '0;
                if (tx_valid && tx_ready_q) begin
                    // The start bit goes out in the very next cycle, so the
                    // line is driven low from this edge on.
                    state_d    = START;
                    shift_d    = tx_data;
                    parity_d   = ^tx_data;
                    sout_d     = 1'b0;
                    tx_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end

            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    sout_d    = shift_q[0];
                    shift_d   = shift_q >> 1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d = PARITY;
                        sout_d  = parity_q;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        sout_d    = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    cnt_d   = '0;
                    sout_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            STOP: begin
                if (bit_end) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    sout_d     = 1'b1;
                    tx_ready_d = 1'b1;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                // Corrupted state register: fall back to a clean idle line.
                state_d    = IDLE;
                cnt_d      = '0;
                bit_cnt_d  = '0;
                sout_d     = 1'b1;
                tx_ready_d = 1'b1;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            sout_q     <= 1'b1;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            sout_q     <= sout_d;
            tx_ready_q <= tx_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign sout     = sout_q;
    assign tx_ready = tx_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_serial_bit_tx.sv
// ---------------------------------------------------------------------------
// tb_serial_bit_tx
//
// Two instances: dut4 (CLKS_PER_BIT=4, DATA_W=8) and dut1 (CLKS_PER_BIT=1).
// Expected line values come from exp_sout(), which builds the frame from
// its definition (start 0, data LSB first, even parity, stop 1) and picks
// the bit for a given cycle offset after the accepting edge.
// Inputs change on the falling edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_serial_bit_tx;

    localparam int N4 = 11 * 4;
    localparam int N1 = 11;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;

    logic [7:0] tx_data4  = '0;
    logic       tx_valid4 = 1'b0;
    logic       tx_ready4, sout4, busy4, done4;

    logic [7:0] tx_data1  = '0;
    logic       tx_valid1 = 1'b0;
    logic       tx_ready1, sout1, busy1, done1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_bit_tx #(.CLKS_PER_BIT(4), .DATA_W(8)) dut4 (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data4),
        .tx_valid (tx_valid4),
        .tx_ready (tx_ready4),
        .sout     (sout4),
        .busy     (busy4),
        .done     (done4)
    );

    serial_bit_tx #(.CLKS_PER_BIT(1), .DATA_W(8)) dut1 (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data1),
        .tx_valid (tx_valid1),
        .tx_ready (tx_ready1),
        .sout     (sout1),
        .busy     (busy1),
        .done     (done1)
    );

    // Line value 'cyc' cycles after the accepting edge (cyc < 11*cpb).
    function automatic logic exp_sout(input logic [7:0] d, input int cpb, input int cyc);
        int b;
        b = cyc / cpb;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (b == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic test_reset();
        #1 reset = 1'b1;
        #2;
        checks++; if ({sout4, tx_ready4, busy4, done4} !== 4'b1100) begin
            failures++; $display("FAIL reset_async4 got=%b exp=1100", {sout4, tx_ready4, busy4, done4});
        end
        checks++; if ({sout1, tx_ready1, busy1, done1} !== 4'b1100) begin
            failures++; $display("FAIL reset_async1 got=%b exp=1100", {sout1, tx_ready1, busy1, done1});
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if ({sout4, tx_ready4, busy4, done4} !== 4'b1100) begin
            failures++; $display("FAIL reset_idle4 got=%b exp=1100", {sout4, tx_ready4, busy4, done4});
        end
        $display("reset: outputs idle after release");
    endtask

    // Single frames: two fixed words plus random ones, random idle gaps,
    // random tx_data/tx_valid activity while busy.
    task automatic test_frames();
        logic [7:0] words [0:7];
        logic [7:0] d;
        int         gap, ready_low, busy_cnt, done_cnt, done_at;
        words[0] = 8'hA5;
        words[1] = 8'h07;
        for (int k = 2; k < 8; k++) words[k] = 8'($urandom);
        for (int k = 0; k < 8; k++) begin
            d   = words[k];
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                checks++; if ({sout4, tx_ready4, busy4} !== 3'b110) begin
                    failures++; $display("FAIL frame_idle got=%b exp=110", {sout4, tx_ready4, busy4});
                end
            end
            @(negedge clk);
            tx_data4  = d;
            tx_valid4 = 1'b1;
            @(posedge clk);
            ready_low = 0; busy_cnt = 0; done_cnt = 0; done_at = -1;
            for (int i = 0; i <= N4 + 1; i++) begin
                @(negedge clk);
                tx_data4  = 8'($urandom);
                tx_valid4 = (i < N4 - 1) ? 1'($urandom) : 1'b0;
                if (tx_ready4 === 1'b0) ready_low++;
                if (busy4 === 1'b1) busy_cnt++;
                if (done4 === 1'b1) begin done_cnt++; done_at = i; end
                checks++; if (sout4 !== ((i < N4) ? exp_sout(d, 4, i) : 1'b1)) begin
                    failures++; $display("FAIL frame_sout data=%h cyc=%0d got=%b exp=%b",
                                         d, i, sout4, (i < N4) ? exp_sout(d, 4, i) : 1'b1);
                end
                checks++; if (busy4 !== ~tx_ready4) begin
                    failures++; $display("FAIL frame_busy_inv cyc=%0d busy=%b ready=%b", i, busy4, tx_ready4);
                end
            end
            checks++; if (ready_low != N4) begin
                failures++; $display("FAIL frame_ready_low data=%h got=%0d exp=%0d", d, ready_low, N4);
            end
            checks++; if (busy_cnt != N4) begin
                failures++; $display("FAIL frame_busy_len data=%h got=%0d exp=%0d", d, busy_cnt, N4);
            end
            checks++; if (done_cnt != 1 || done_at != N4) begin
                failures++; $display("FAIL frame_done data=%h count=%0d at=%0d exp count=1 at=%0d",
                                     d, done_cnt, done_at, N4);
            end
            $display("frame: data=%h gap=%0d done_at=%0d busy=%0d", d, gap, done_at, busy_cnt);
        end
    endtask

    // tx_data flips 0x00 -> 0xFF right after acceptance; the frame keeps 0x00.
    task automatic test_ignore_busy();
        @(negedge clk);
        tx_data4  = 8'h00;
        tx_valid4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_data4  = 8'hFF;
        tx_valid4 = 1'b0;
        checks++; if (sout4 !== 1'b0) begin
            failures++; $display("FAIL ignore_start got=%b exp=0", sout4);
        end
        for (int i = 1; i < N4; i++) begin
            @(negedge clk);
            checks++; if (sout4 !== 1'(i >= 40)) begin
                failures++; $display("FAIL ignore_sout cyc=%0d got=%b exp=%b", i, sout4, 1'(i >= 40));
            end
        end
        @(negedge clk);
        checks++; if (done4 !== 1'b1) begin
            failures++; $display("FAIL ignore_done got=%b exp=1", done4);
        end
        $display("ignore_busy: 0x00 frame sent while tx_data=0xFF");
    endtask

    task automatic test_back_to_back();
        int    done_cnt, gap_cnt;
        logic  es, er, ed;
        @(negedge clk);
        tx_data4  = 8'h3C;
        tx_valid4 = 1'b1;
        @(posedge clk);
        done_cnt = 0; gap_cnt = 0;
        for (int i = 0; i <= 2 * N4 + 2; i++) begin
            @(negedge clk);
            if (i == 0) tx_data4 = 8'hFF;
            if (i == N4 + 1) tx_valid4 = 1'b0;
            if (i < N4) begin
                es = exp_sout(8'h3C, 4, i); er = 1'b0; ed = 1'b0;
            end else if (i == N4) begin
                es = 1'b1; er = 1'b1; ed = 1'b1;
            end else if (i <= 2 * N4) begin
                es = exp_sout(8'hFF, 4, i - N4 - 1); er = 1'b0; ed = 1'b0;
            end else begin
                es = 1'b1; er = 1'b1; ed = (i == 2 * N4 + 1);
            end
            if (done4 === 1'b1) done_cnt++;
            if (i > 0 && i <= 2 * N4 && tx_ready4 === 1'b1 && sout4 === 1'b1) gap_cnt++;
            checks++; if ({sout4, tx_ready4, done4} !== {es, er, ed}) begin
                failures++; $display("FAIL b2b cyc=%0d got sout/ready/done=%b exp=%b",
                                     i, {sout4, tx_ready4, done4}, {es, er, ed});
            end
        end
        checks++; if (done_cnt != 2) begin
            failures++; $display("FAIL b2b_done_count got=%0d exp=2", done_cnt);
        end
        checks++; if (gap_cnt != 1) begin
            failures++; $display("FAIL b2b_gap got=%0d exp=1", gap_cnt);
        end
        $display("back_to_back: 3C then FF done_pulses=%0d idle_gap=%0d", done_cnt, gap_cnt);
    endtask

    task automatic test_reset_midframe();
        int done_cnt;
        @(negedge clk);
        tx_data4  = 8'hC3;
        tx_valid4 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid4 = 1'b0;
        // Data bit 3 occupies cycles 16..19 after acceptance.
        repeat (17) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if ({sout4, tx_ready4, busy4, done4} !== 4'b1100) begin
            failures++; $display("FAIL midreset_async got=%b exp=1100", {sout4, tx_ready4, busy4, done4});
        end
        @(negedge clk);
        reset     = 1'b0;
        checks++; if ({sout4, tx_ready4, busy4, done4} !== 4'b1100) begin
            failures++; $display("FAIL midreset_held got=%b exp=1100", {sout4, tx_ready4, busy4, done4});
        end
        tx_data4  = 8'h5A;
        tx_valid4 = 1'b1;
        @(posedge clk);
        done_cnt = 0;
        for (int i = 0; i <= N4; i++) begin
            @(negedge clk);
            tx_valid4 = 1'b0;
            if (done4 === 1'b1) done_cnt++;
            checks++; if (sout4 !== ((i < N4) ? exp_sout(8'h5A, 4, i) : 1'b1)) begin
                failures++; $display("FAIL midreset_5a cyc=%0d got=%b exp=%b",
                                     i, sout4, (i < N4) ? exp_sout(8'h5A, 4, i) : 1'b1);
            end
        end
        checks++; if (done_cnt != 1 || done4 !== 1'b1) begin
            failures++; $display("FAIL midreset_done count=%0d last=%b exp count=1 last=1", done_cnt, done4);
        end
        $display("reset_midframe: aborted C3, then 5A frame done_pulses=%0d", done_cnt);
    endtask

    task automatic test_cpb1();
        logic [10:0] pat;
        logic [7:0]  d;
        pat = 11'b101_0000_0010;    // bit i = line value in cycle i for 0x81
        for (int k = 0; k < 4; k++) begin
            d = (k == 0) ? 8'h81 : 8'($urandom);
            @(negedge clk);
            tx_data1  = d;
            tx_valid1 = 1'b1;
            @(posedge clk);
            for (int i = 0; i <= N1; i++) begin
                @(negedge clk);
                tx_valid1 = 1'b0;
                tx_data1  = 8'($urandom);
                if (i < N1) begin
                    checks++; if (sout1 !== exp_sout(d, 1, i)) begin
                        failures++; $display("FAIL cpb1_sout data=%h cyc=%0d got=%b exp=%b",
                                             d, i, sout1, exp_sout(d, 1, i));
                    end
                    if (k == 0) begin
                        checks++; if (sout1 !== pat[i]) begin
                            failures++; $display("FAIL cpb1_81 cyc=%0d got=%b exp=%b", i, sout1, pat[i]);
                        end
                    end
                end
                checks++; if (done1 !== 1'(i == N1)) begin
                    failures++; $display("FAIL cpb1_done data=%h cyc=%0d got=%b exp=%b",
                                         d, i, done1, 1'(i == N1));
                end
            end
            $display("cpb1: data=%h sent in %0d cycles", d, N1);
        end
    endtask

    initial begin
        test_reset();
        test_frames();
        test_ignore_busy();
        test_back_to_back();
        test_reset_midframe();
        test_cpb1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
